sync_fifo_wl: RTL and testbench

Parametrised single-clock FIFO. It is the successor to the fixed-geometry 8192x11 vendor FIFO used on the acquisition path.
- Adds runtime-programmable almost-full/almost-empty thresholds, an optional first-word-fall-through (FWFT) read mode, a synchronous flush, and sticky overflow/underflow error flags.
- Sits between single-clock-domain producers/consumers (decimator → framer) where the async IP is unnecessary.

---
 rtl/sync_fifo_pkg.sv | 19 +
 rtl/sync_fifo_wl_if.sv | 41 ++++
 rtl/sync_fifo_ram.sv | 35 +++
 rtl/sync_fifo_wl.sv | 148 ++++++++++++++
 tb/tb_sync_fifo_wl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo_wl block.
//   DEF_DATA_WIDTH / DEF_DEPTH_WIDTH : default geometry of the acquisition-path FIFO (8192 x 11)
//   fifo_depth()                     : capacity in words for a given log2 depth
//   level_width()                    : width of pointers, level and thresholds (holds 0..DEPTH)
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH  = 11;
  localparam int DEF_DEPTH_WIDTH = 13;

  function automatic int fifo_depth(input int depth_width);
    return 1 << depth_width;
  endfunction

  // One extra bit so a completely full FIFO (level == DEPTH) is representable.
  function automatic int level_width(input int depth_width);
    return depth_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_wl_if.sv
// Handshake/status bundle of sync_fifo_wl.
//   master : the producer/consumer side (drives requests, data, thresholds, err_clr)
//   slave  : the FIFO itself (drives full/empty/level/flags and read data)
interface sync_fifo_wl_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH_WIDTH = DEF_DEPTH_WIDTH
);
  localparam int LW = level_width(DEPTH_WIDTH);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_empty;
  logic                  almost_empty;
  logic [LW-1:0]         water_level;
  logic [LW-1:0]         af_thresh;
  logic [LW-1:0]         ae_thresh;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;

  modport master (
    output flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    input  wr_full, almost_full, rd_data, rd_valid, rd_empty, almost_empty,
           water_level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    output wr_full, almost_full, rd_data, rd_valid, rd_empty, almost_empty,
           water_level, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM, DATA_WIDTH x 2**ADDR_WIDTH, one write port and one
// registered read port (1-cycle latency). Written to map onto block RAM.
//   clk, rst_n       : clock, synchronous active-low reset (read register only)
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request; rd_data updates on the following edge
//   rd_data          : registered read word, held when rd_en is low
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // NOTE: the array has no reset on purpose -- a reset loop over every word
  // prevents block-RAM inference; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_wl.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, optional first-word-fall-through read, synchronous flush and
// sticky overflow/underflow flags.
//   clk   : single clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : sync_fifo_wl_if.slave -- write/read handshakes, data, level,
//           thresholds and error flags
module sync_fifo_wl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH_WIDTH = DEF_DEPTH_WIDTH,
  parameter bit FWFT        = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  sync_fifo_wl_if.slave bus
);
  localparam int            LW    = level_width(DEPTH_WIDTH);
  localparam logic [LW-1:0] DEPTH = LW'(fifo_depth(DEPTH_WIDTH));

  logic [LW-1:0]         wr_ptr, rd_ptr, level, level_next;
  logic                  wacc, racc, ram_rd, rd_empty_w;
  logic                  wr_full_q, almost_full_q, almost_empty_q;
  logic                  overflow_q, underflow_q;
  logic [DATA_WIDTH-1:0] ram_q;

  // NOTE: every signal written here gets a value on every path, otherwise
  // synthesis infers a latch to hold the old value.
  always_comb begin
    wacc       = bus.wr_en & ~wr_full_q & ~bus.flush;
    racc       = bus.rd_en & ~rd_empty_w & ~bus.flush;
    level_next = level + LW'(wacc) - LW'(racc);
    if (bus.flush) level_next = '0;
  end

  // Status flags are registered from level_next, so they move in the same
  // cycle as water_level.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      wr_full_q      <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wacc)   wr_ptr <= wr_ptr + LW'(1);
        if (ram_rd) rd_ptr <= rd_ptr + LW'(1);
      end
      level          <= level_next;
      wr_full_q      <= (level_next == DEPTH);
      almost_full_q  <= (level_next >= bus.af_thresh);
      almost_empty_q <= (level_next <= bus.ae_thresh);
      // A new error event takes priority over a same-cycle clear.
      if (bus.wr_en & wr_full_q & ~bus.flush) overflow_q  <= 1'b1;
      else if (bus.err_clr)                   overflow_q  <= 1'b0;
      if (bus.rd_en & rd_empty_w & ~bus.flush) underflow_q <= 1'b1;
      else if (bus.err_clr)                    underflow_q <= 1'b0;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(DEPTH_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wacc),
    .wr_addr(wr_ptr[DEPTH_WIDTH-1:0]),
    .wr_data(bus.wr_data),
    .rd_en  (ram_rd),
    .rd_addr(rd_ptr[DEPTH_WIDTH-1:0]),
    .rd_data(ram_q)
  );

  if (FWFT == 1'b0) begin : g_std
    logic rd_empty_q, rd_valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_empty_q <= 1'b1;
        rd_valid_q <= 1'b0;
      end else begin
        rd_empty_q <= (level_next == '0);
        rd_valid_q <= racc;
      end
    end

    assign ram_rd       = racc;
    assign rd_empty_w   = rd_empty_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = ram_q;
  end else begin : g_fwft
    // Two-deep prefetch: the RAM output register (q) and the presented stage.
    // Keeping q full lets a pop reload the stage on the same edge, which is
    // what sustains one word per cycle. rd_ptr counts RAM reads issued, so
    // wr_ptr - rd_ptr is the number of words still sitting in the array.
    logic                  stage_valid, q_valid, stage_load;
    logic [DATA_WIDTH-1:0] stage_data;
    logic [LW-1:0]         ram_cnt;

    assign ram_cnt    = wr_ptr - rd_ptr;
    assign stage_load = q_valid & (~stage_valid | racc);
    assign ram_rd     = ~bus.flush & (ram_cnt != '0) & (~q_valid | stage_load);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stage_valid <= 1'b0;
        q_valid     <= 1'b0;
        stage_data  <= '0;
      end else if (bus.flush) begin
        stage_valid <= 1'b0;
        q_valid     <= 1'b0;
      end else begin
        if (stage_load) begin
          stage_valid <= 1'b1;
          stage_data  <= ram_q;
        end else if (racc) begin
          stage_valid <= 1'b0;
        end
        if (ram_rd)          q_valid <= 1'b1;
        else if (stage_load) q_valid <= 1'b0;
      end
    end

    assign rd_empty_w   = ~stage_valid;
    assign bus.rd_valid = stage_valid;
    assign bus.rd_data  = stage_data;
  end

  assign bus.rd_empty     = rd_empty_w;
  assign bus.wr_full      = wr_full_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.water_level  = level;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_wl.sv
// Bench for sync_fifo_wl: one standard-mode and one FWFT instance (16 deep,
// 11 bits) share the same stimulus. A queue model per instance predicts all
// outputs every cycle; directed steps add hand-computed literal checks.
module tb_sync_fifo_wl;
  localparam int DW    = 11;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk, rst_n;
  logic flush, wr_en, rd_en, err_clr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   af_thr, ae_thr;

  int total = 0;
  int bad   = 0;
  bit armed = 0;
  int cyc   = 0;

  sync_fifo_wl_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) bs ();
  sync_fifo_wl_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) bf ();

  assign bs.flush = flush;   assign bf.flush = flush;
  assign bs.wr_en = wr_en;   assign bf.wr_en = wr_en;
  assign bs.wr_data = wr_data; assign bf.wr_data = wr_data;
  assign bs.rd_en = rd_en;   assign bf.rd_en = rd_en;
  assign bs.err_clr = err_clr; assign bf.err_clr = err_clr;
  assign bs.af_thresh = af_thr; assign bf.af_thresh = af_thr;
  assign bs.ae_thresh = ae_thr; assign bf.ae_thresh = ae_thr;

  sync_fifo_wl #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(1'b0)) dut_std (
    .clk(clk), .rst_n(rst_n), .bus(bs.slave));
  sync_fifo_wl #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .bus(bf.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (index 0 = standard, 1 = FWFT) -------
  logic [DW-1:0] mq [2][$];   // words held, head first
  int            mt [2][$];   // edge number at which each word was written
  logic [DW-1:0] m_rdata [2];
  bit m_rvalid [2], m_empty [2], m_full [2], m_af [2], m_ae [2], m_ovf [2], m_unf [2];

  // FWFT rule: the head word is presented once it was written at least two
  // edges ago (RAM read + stage load), independent of how it became head.
  task automatic model_step(input int m);
    bit wacc, racc;
    logic [DW-1:0] popped;
    int sz;
    popped = '0;
    if (!rst_n) begin
      mq[m].delete(); mt[m].delete();
      m_rdata[m] = '0; m_rvalid[m] = 0; m_empty[m] = 1; m_full[m] = 0;
      m_af[m] = 0; m_ae[m] = 1; m_ovf[m] = 0; m_unf[m] = 0;
      return;
    end
    wacc = wr_en && !m_full[m] && !flush;
    racc = rd_en && !m_empty[m] && !flush;
    if (wr_en && m_full[m] && !flush) m_ovf[m] = 1; else if (err_clr) m_ovf[m] = 0;
    if (rd_en && m_empty[m] && !flush) m_unf[m] = 1; else if (err_clr) m_unf[m] = 0;
    if (flush) begin
      mq[m].delete(); mt[m].delete();
    end else begin
      if (racc) begin popped = mq[m].pop_front(); void'(mt[m].pop_front()); end
      if (wacc) begin mq[m].push_back(wr_data); mt[m].push_back(cyc); end
    end
    sz = mq[m].size();
    m_full[m] = (sz == DEPTH);
    m_af[m]   = (sz >= int'(af_thr));
    m_ae[m]   = (sz <= int'(ae_thr));
    if (m == 0) begin
      m_empty[m]  = (sz == 0);
      m_rvalid[m] = racc;
      if (racc) m_rdata[m] = popped;
    end else begin
      m_empty[m]  = !(sz > 0 && cyc >= mt[m][0] + 2);
      m_rvalid[m] = !m_empty[m];
      if (!m_empty[m]) m_rdata[m] = mq[m][0];
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    model_step(0);
    model_step(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input int m, input logic [AW:0] lvl,
                     input logic full, input logic af, input logic ae,
                     input logic empty, input logic valid, input logic [DW-1:0] data,
                     input logic ovf, input logic unf);
    check({tag, ".level"},    32'(lvl),   32'(mq[m].size()));
    check({tag, ".wr_full"},  32'(full),  32'(m_full[m]));
    check({tag, ".af"},       32'(af),    32'(m_af[m]));
    check({tag, ".ae"},       32'(ae),    32'(m_ae[m]));
    check({tag, ".rd_empty"}, 32'(empty), 32'(m_empty[m]));
    check({tag, ".rd_valid"}, 32'(valid), 32'(m_rvalid[m]));
    check({tag, ".overflow"}, 32'(ovf),   32'(m_ovf[m]));
    check({tag, ".underflow"},32'(unf),   32'(m_unf[m]));
    if (m == 0 || !m_empty[m]) check({tag, ".rd_data"}, 32'(data), 32'(m_rdata[m]));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp("std", 0, bs.water_level, bs.wr_full, bs.almost_full, bs.almost_empty,
          bs.rd_empty, bs.rd_valid, bs.rd_data, bs.overflow, bs.underflow);
      cmp("fwft", 1, bf.water_level, bf.wr_full, bf.almost_full, bf.almost_empty,
          bf.rd_empty, bf.rd_valid, bf.rd_data, bf.overflow, bf.underflow);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; flush = 0; wr_en = 0; rd_en = 0; err_clr = 0;
    wr_data = '0; af_thr = 5'd12; ae_thr = 5'd3;
    tick(2);
    armed = 1;
    check("rst.std_empty", 32'(bs.rd_empty), 1);
    check("rst.std_full",  32'(bs.wr_full), 0);
    check("rst.std_ae",    32'(bs.almost_empty), 1);
    check("rst.std_af",    32'(bs.almost_full), 0);
    check("rst.std_data",  32'(bs.rd_data), 0);
    check("rst.fwft_empty",32'(bf.rd_empty), 1);
    rst_n = 1'b1;

    // Fill to full; thresholds 12/3 move with water_level.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_data = DW'(11'h7FF - i);
      tick();
      check("fill.level", 32'(bs.water_level), 32'(i + 1));
      check("fill.ae",    32'(bs.almost_empty), 32'((i + 1) <= 3));
      check("fill.af",    32'(bs.almost_full),  32'((i + 1) >= 12));
    end
    wr_en = 0;
    check("full.std", 32'(bs.wr_full), 1);
    check("full.fwft", 32'(bf.wr_full), 1);

    // Write+read while full: write rejected, read accepted.
    wr_en = 1; rd_en = 1; wr_data = 11'h555;
    tick();
    wr_en = 0;
    check("wfull.level", 32'(bs.water_level), 15);
    check("wfull.ovf",   32'(bs.overflow), 1);
    check("wfull.data",  32'(bs.rd_data), 32'h7FF);

    // Drain remaining 15 back to back.
    for (int i = 0; i < 15; i++) begin
      check("drain.fwft_data", 32'(bf.rd_data), 32'(11'h7FE - i));
      tick();
      check("drain.std_data",  32'(bs.rd_data), 32'(11'h7FE - i));
      check("drain.std_valid", 32'(bs.rd_valid), 1);
    end
    rd_en = 0;
    tick();
    check("drain.std_empty", 32'(bs.rd_empty), 1);
    check("drain.fwft_empty", 32'(bf.rd_empty), 1);
    check("drain.std_valid0", 32'(bs.rd_valid), 0);

    // FWFT latency: written at edge N, presented after edge N+2.
    wr_en = 1; wr_data = 11'h123;
    tick();
    wr_en = 0;
    check("lat.std_n",   32'(bs.rd_empty), 0);
    check("lat.fwft_n",  32'(bf.rd_empty), 1);
    tick();
    check("lat.fwft_n1", 32'(bf.rd_empty), 1);
    tick();
    check("lat.fwft_n2", 32'(bf.rd_empty), 0);
    check("lat.fwft_dat",32'(bf.rd_data), 32'h123);
    rd_en = 1;
    tick();
    rd_en = 0;
    check("lat.std_dat", 32'(bs.rd_data), 32'h123);

    // Eight stored words popped on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_data = DW'(11'h100 + i);
      tick();
    end
    wr_en = 0;
    tick(3);
    rd_en = 1;
    for (int i = 0; i < 8; i++) begin
      check("b2b.fwft_empty", 32'(bf.rd_empty), 0);
      check("b2b.fwft_data",  32'(bf.rd_data), 32'(11'h100 + i));
      tick();
    end
    rd_en = 0;
    check("b2b.fwft_end", 32'(bf.rd_empty), 1);

    // Flush at level 9 with a write pending; overflow still set from above.
    for (int i = 0; i < 9; i++) begin
      wr_en = 1; wr_data = DW'(11'h200 + i);
      tick();
    end
    wr_en = 0;
    tick(3);
    check("fl.pre_level", 32'(bs.water_level), 9);
    flush = 1; wr_en = 1; wr_data = 11'h2AA;
    tick();
    flush = 0; wr_en = 0;
    check("fl.level", 32'(bs.water_level), 0);
    check("fl.fwft_level", 32'(bf.water_level), 0);
    check("fl.empty", 32'(bs.rd_empty), 1);
    check("fl.ovf", 32'(bs.overflow), 1);
    rd_en = 1;
    tick();
    rd_en = 0;
    check("unf.set", 32'(bs.underflow), 1);
    rd_en = 1; err_clr = 1;          // set and clear together: set wins
    tick();
    rd_en = 0;
    check("unf.win", 32'(bs.underflow), 1);
    check("ovf.clr", 32'(bs.overflow), 0);
    tick();
    err_clr = 0;
    check("unf.clr", 32'(bf.underflow), 0);

    // Threshold corners.
    af_thr = 5'd0; ae_thr = 5'd16;
    tick();
    check("thr.af0", 32'(bs.almost_full), 1);
    af_thr = 5'd12; ae_thr = 5'd3;

    // Reset mid-stream at level 7.
    for (int i = 0; i < 7; i++) begin
      wr_en = 1; wr_data = DW'(11'h300 + i);
      tick();
    end
    wr_en = 0;
    check("mrst.pre", 32'(bs.water_level), 7);
    rst_n = 0;
    tick();
    check("mrst.level", 32'(bs.water_level), 0);
    check("mrst.empty", 32'(bf.rd_empty), 1);
    check("mrst.data",  32'(bs.rd_data), 0);
    check("mrst.ae",    32'(bs.almost_empty), 1);
    rst_n = 1;
    wr_en = 1; wr_data = 11'h3AB;
    tick();
    wr_en = 0;
    tick(2);
    check("mrst.fwft_dat", 32'(bf.rd_data), 32'h3AB);
    rd_en = 1;
    tick();
    rd_en = 0;
    check("mrst.std_dat", 32'(bs.rd_data), 32'h3AB);

    // Mixed traffic: fill-heavy, drain-heavy, then balanced with flush/err_clr.
    for (int i = 0; i < 450; i++) begin
      int pw, pr;
      pw = (i < 150) ? 80 : (i < 300) ? 25 : 55;
      pr = (i < 150) ? 30 : (i < 300) ? 85 : 50;
      wr_en   = ($urandom_range(99) < pw);
      rd_en   = ($urandom_range(99) < pr);
      wr_data = DW'($urandom_range(2047));
      flush   = (i % 97 == 96);
      err_clr = (i % 53 == 52);
      af_thr  = (AW+1)'(i % 18);
      ae_thr  = (AW+1)'((i / 3) % 18);
      tick();
    end
    wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
